sub_bytes_ctrl: RTL and testbench

- Sequences the AES SubBytes step over one 128-bit state, time-sharing LANES registered S-box lookup units across the 16 state bytes.
- Sits between the AES round controller (start/done handshake) and the round datapath (state_in / state_out).
- Replaces per-byte software-style pulsing of a lookup: one start yields one fully substituted state and a single done pulse.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox_lut.sv | 34 +++
 rtl/sub_bytes_ctrl.sv | 150 +++++++++++++++
 tb/tb_sub_bytes_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES SubBytes sequencer: the forward S-box
// table, the inverse S-box table (present only with INV_SBOX_EN), the state
// byte-array type and the controller FSM encoding.
// Macro: INV_SBOX_EN - adds the INV_SBOX table.
package aes_pkg;

  localparam int NUM_BYTES = 16;

  // byte i occupies bits [8i+7:8i] of the flat 128-bit state
  typedef logic [NUM_BYTES-1:0][7:0] byte_array_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef INV_SBOX_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_lut.sv
// One registered S-box lookup lane. The looked-up byte appears on data one
// clk edge after addr is presented.
// Macro: INV_SBOX_EN - adds the inv input selecting the inverse table.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset, clears data
//   addr   byte to substitute
//   inv    (INV_SBOX_EN only) 1 = inverse table
//   data   registered substituted byte
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] addr,
`ifdef INV_SBOX_EN
  input  logic       inv,
`endif
  output logic [7:0] data
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data <= '0;
    end else begin
`ifdef INV_SBOX_EN
      data <= inv ? INV_SBOX[addr] : SBOX[addr];
`else
      data <= SBOX[addr];
`endif
    end
  end

endmodule

// File: rtl/sub_bytes_ctrl.sv
// AES SubBytes sequencer. One accepted start substitutes all 16 bytes of a
// 128-bit state using LANES registered S-box lanes, then pulses done for one
// cycle with the result on state_out.
// Macro: INV_SBOX_EN - adds inv_mode (captured with state_in) to select
//        InvSubBytes for the whole operation.
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   clear      synchronous abort back to IDLE
//   state_in   input state, byte i = state_in[8i+7:8i]
//   inv_mode   (INV_SBOX_EN only) 1 = inverse S-box
//   busy       high in ISSUE and DRAIN
//   done       one-cycle pulse in DONE
//   state_out  substituted state, valid with done and held afterwards
//
// state | meaning
// IDLE  | waiting for start; state_in captured on acceptance
// ISSUE | group g (0..GROUPS-1) of LANES bytes presented to the lanes
// DRAIN | last group's lookup lands in the working buffer
// DONE  | done pulse, state_out shows the working buffer
module sub_bytes_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         clear,
  input  logic [127:0] state_in,
`ifdef INV_SBOX_EN
  input  logic         inv_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int GROUPS = NUM_BYTES / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_ctrl: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_state_e       st_q, st_nxt;
  logic [CNT_W-1:0] grp_q;
  logic [CNT_W-1:0] wb_grp_q;
  logic             lut_valid_q;
  byte_array_t      work_q, work_nxt;
  byte_array_t      out_q;
  logic             accept;
  logic             last_grp;
  logic [3:0]       rd_base, wb_base;
  logic [7:0]       lut_addr [LANES];
  logic [7:0]       lut_data [LANES];
`ifdef INV_SBOX_EN
  logic             inv_q;
`endif

  assign accept   = (st_q == IDLE) && start && !clear;
  assign last_grp = (grp_q == CNT_W'(GROUPS - 1));
  assign rd_base  = 4'(int'(grp_q) * LANES);
  assign wb_base  = 4'(int'(wb_grp_q) * LANES);

  always_comb begin
    st_nxt = st_q;
    case (st_q)
      IDLE:    if (start) st_nxt = ISSUE;
      ISSUE:   if (last_grp) st_nxt = DRAIN;
      DRAIN:   st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    if (clear) st_nxt = IDLE;
  end

  // The lanes read group g while the previous group is written back, so the
  // read and write byte ranges are always disjoint.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lut_addr[l] = work_q[rd_base + 4'(l)];
    end
  end

  always_comb begin
    work_nxt = work_q;
    if (accept) begin
      work_nxt = state_in;
    end else if (lut_valid_q) begin
      for (int l = 0; l < LANES; l++) begin
        work_nxt[wb_base + 4'(l)] = lut_data[l];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lut u_lut (
      .clk   (clk),
      .n_rst (n_rst),
      .addr  (lut_addr[l]),
`ifdef INV_SBOX_EN
      .inv   (inv_q),
`endif
      .data  (lut_data[l])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st_q        <= IDLE;
      grp_q       <= '0;
      wb_grp_q    <= '0;
      lut_valid_q <= 1'b0;
      work_q      <= '0;
      out_q       <= '0;
    end else begin
      st_q        <= st_nxt;
      work_q      <= work_nxt;
      wb_grp_q    <= grp_q;
      lut_valid_q <= (st_q == ISSUE) && !clear;
      if ((st_q == ISSUE) && !clear && !last_grp) begin
        grp_q <= grp_q + 1'b1;
      end else begin
        grp_q <= '0;
      end
      if (st_q == DONE) begin
        out_q <= work_q;
      end
    end
  end

`ifdef INV_SBOX_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= inv_mode;
    end
  end
`endif

  // During DONE the buffer is shown directly; afterwards the latched copy
  // holds it so later operations do not disturb state_out until they finish.
  assign busy      = (st_q == ISSUE) || (st_q == DRAIN);
  assign done      = (st_q == DONE);
  assign state_out = (st_q == DONE) ? work_q : out_q;

endmodule

// File: tb/tb_sub_bytes_ctrl.sv
module tb_sub_bytes_ctrl;

  localparam logic [127:0] ZERO_IN  = 128'h0;
  localparam logic [127:0] SUB_63   = {16{8'h63}};
  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] RST_IN   = 128'h0000000000000000000000000001ff53;
  localparam logic [127:0] RST_OUT  = 128'h636363636363636363636363637c16ed;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         clear;
  logic [127:0] state_in;
`ifdef INV_SBOX_EN
  logic         inv_mode;
`endif
  logic         busy1, busy4, busy16;
  logic         done1, done4, done16;
  logic [127:0] out1, out4, out16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sub_bytes_ctrl #(.LANES(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start), .clear(clear), .state_in(state_in),
`ifdef INV_SBOX_EN
    .inv_mode(inv_mode),
`endif
    .busy(busy1), .done(done1), .state_out(out1));

  sub_bytes_ctrl #(.LANES(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start(start), .clear(clear), .state_in(state_in),
`ifdef INV_SBOX_EN
    .inv_mode(inv_mode),
`endif
    .busy(busy4), .done(done4), .state_out(out4));

  sub_bytes_ctrl #(.LANES(16)) u_dut16 (
    .clk(clk), .n_rst(n_rst), .start(start), .clear(clear), .state_in(state_in),
`ifdef INV_SBOX_EN
    .inv_mode(inv_mode),
`endif
    .busy(busy16), .done(done16), .state_out(out16));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One start pulse accepted at edge 0; records the first edge after which
  // each DUT shows done, its state_out then, and the done count of LANES=1.
  task automatic run_op(input logic [127:0] din,
                        output int e1, output int e4, output int e16,
                        output logic [127:0] o1, output logic [127:0] o4,
                        output logic [127:0] o16, output int n1);
    e1 = -1; e4 = -1; e16 = -1; n1 = 0;
    o1 = '0; o4 = '0; o16 = '0;
    @(negedge clk);
    state_in = din;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_rise", {busy16, busy4, busy1}, 3'b111);
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        n1++;
        if (e1 < 0) begin e1 = e; o1 = out1; end
      end
      if (done4 && e4 < 0) begin e4 = e; o4 = out4; end
      if (done16 && e16 < 0) begin e16 = e; o16 = out16; end
    end
  endtask

  int           e1, e4, e16, n1, nd;
  logic [127:0] o1, o4, o16;
  int           de [3];
  logic [127:0] dout [3];

  initial begin
    n_rst    = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    state_in = '0;
`ifdef INV_SBOX_EN
    inv_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("rst_busy", {busy16, busy4, busy1}, 3'b000);
    check_val("rst_done", {done16, done4, done1}, 3'b000);
    check_val("rst_out1", out1, '0);
    check_val("rst_out16", out16, '0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // all-zero state
    run_op(ZERO_IN, e1, e4, e16, o1, o4, o16, n1);
    check_val("zero_done_edge1", 128'(e1), 128'(17));
    check_val("zero_done_count1", 128'(n1), 128'(1));
    check_val("zero_out1", o1, SUB_63);
    check_val("zero_out4", o4, SUB_63);

    // FIPS-197 vector across lane counts
    run_op(FIPS_IN, e1, e4, e16, o1, o4, o16, n1);
    check_val("fips_out1", o1, FIPS_OUT);
    check_val("fips_out4", o4, FIPS_OUT);
    check_val("fips_out16", o16, FIPS_OUT);
    check_val("fips_done_edge4", 128'(e4), 128'(5));
    check_val("fips_done_edge16", 128'(e16), 128'(2));
    check_val("fips_hold1", out1, FIPS_OUT);
    repeat (5) @(negedge clk);

    // start held high: back-to-back operations every 19 cycles for LANES=1
    nd = 0;
    for (int i = 0; i < 3; i++) begin de[i] = -1; dout[i] = '0; end
    @(negedge clk);
    state_in = ZERO_IN;
    start    = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 20) state_in = FIPS_IN;
      if (e == 30) check_val("b2b_hold_mid", out1, SUB_63);
      if (done1) begin
        if (nd < 3) begin de[nd] = e; dout[nd] = out1; end
        nd++;
      end
      if (nd >= 3) start = 1'b0;
    end
    start = 1'b0;
    check_val("b2b_count", 128'(nd), 128'(3));
    check_val("b2b_edge0", 128'(de[0]), 128'(17));
    check_val("b2b_edge1", 128'(de[1]), 128'(36));
    check_val("b2b_edge2", 128'(de[2]), 128'(55));
    check_val("b2b_out0", dout[0], SUB_63);
    check_val("b2b_out1", dout[1], SUB_63);
    check_val("b2b_out2", dout[2], FIPS_OUT);
    repeat (20) @(negedge clk);

    // clear during ISSUE g=7, with a stray start pulse while busy
    n1 = 0;
    state_in = ZERO_IN;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) n1++;
      if (e == 3) begin start = 1'b1; state_in = RST_IN; end
      if (e == 4) start = 1'b0;
    end
    check_val("clr_busy_before", 128'(busy1), 128'(1));
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check_val("clr_busy", 128'(busy1), 128'(0));
    check_val("clr_done", 128'(done1), 128'(0));
    check_val("clr_out_kept", out1, FIPS_OUT);
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) n1++;
    end
    check_val("clr_no_done", 128'(n1), 128'(0));
    repeat (5) @(negedge clk);

    // asynchronous reset in the middle of ISSUE
    state_in = FIPS_IN;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("arst_busy", {busy16, busy4, busy1}, 3'b000);
    check_val("arst_done", {done16, done4, done1}, 3'b000);
    check_val("arst_out1", out1, '0);
    check_val("arst_out4", out4, '0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    run_op(RST_IN, e1, e4, e16, o1, o4, o16, n1);
    check_val("post_rst_out1", o1, RST_OUT);
    check_val("post_rst_out4", o4, RST_OUT);
    check_val("post_rst_out16", o16, RST_OUT);
    check_val("post_rst_edge1", 128'(e1), 128'(17));

`ifdef INV_SBOX_EN
    repeat (5) @(negedge clk);
    inv_mode = 1'b1;
    run_op(SUB_63, e1, e4, e16, o1, o4, o16, n1);
    check_val("inv_out1", o1, '0);
    check_val("inv_out16", o16, '0);
    inv_mode = 1'b0;
    run_op(SUB_63, e1, e4, e16, o1, o4, o16, n1);
    check_val("fwd63_out1", o1, {16{8'hfb}});
    check_val("fwd63_out4", o4, {16{8'hfb}});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
